// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a two-entry skid buffer and branch resolution.
// The ready signal back to EX depends only on registered state.
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic            zero,
  input  logic            sign,
  input  logic [RD_W-1:0] rd_addr,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] store_data,
  input  logic            branch,
  input  logic [2:0]      branch_type,
  input  logic [XLEN-1:0] branch_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_result,
  output logic [RD_W-1:0] out_rd_addr,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [XLEN-1:0] out_store_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_branch
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [RD_W-1:0] rd_addr;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] store_data;
  } entry_t;

  state_t          state_q, state_d;
  entry_t          main_q, main_d, skid_q, skid_d, in_entry;
  logic            redirect_q, redirect_d, illegal_q, illegal_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            accept, drain, taken, legal;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready;

  always_comb begin
    in_entry            = '0;
    in_entry.alu_result = alu_result;
    in_entry.rd_addr    = rd_addr;
    in_entry.reg_write  = reg_write;
    in_entry.mem_read   = mem_read;
    in_entry.mem_write  = mem_write;
    in_entry.store_data = store_data;
  end

  // Flags come straight from the ALU SUB; signed overflow is deliberately not corrected.
  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (branch_type)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = sign;
      3'b101:  taken = ~sign;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    main_d        = main_q;
    skid_d        = skid_q;
    redirect_d    = accept & branch & legal & taken;
    illegal_d     = accept & branch & ~legal;
    redirect_pc_d = redirect_d ? branch_target : redirect_pc_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = in_entry;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      main_q        <= '0;
      skid_q        <= '0;
      redirect_q    <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      main_q        <= main_d;
      skid_q        <= skid_d;
      redirect_q    <= redirect_d;
      illegal_q     <= illegal_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign out_alu_result = main_q.alu_result;
  assign out_rd_addr    = main_q.rd_addr;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_store_data = main_q.store_data;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign illegal_branch = illegal_q;

endmodule
